// File: rtl/serial_adder4_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_adder4_if                                                 |
// | Operand/result handshake bundle for the bit-serial adder.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface serial_adder4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             OV;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, Cout, OV
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, Cout, OV
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_adder4                                                    |
// | Bit-serial two's-complement add/subtract, LSB first, one bit/clk.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module serial_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder4_if.slave   bus
);

  localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_S;
  logic               r_Cout;
  logic               r_OV;

  logic w_s;
  logic w_c;
  logic w_accept;
  logic w_last;
  logic w_busy;
  logic w_done;

  assign w_s      = r_opA[0] ^ r_opB[0] ^ r_carry;
  assign w_c      = (r_opA[0] & r_opB[0]) | (r_opA[0] & r_carry) | (r_opB[0] & r_carry);
  assign w_accept = bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_last   = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_next_state = c_SHIFT;
      c_SHIFT: if (w_last)    w_next_state = c_DONE;
      c_DONE:  w_next_state = bus.start ? c_SHIFT : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_SHIFT: w_busy = 1'b1;
      c_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_S     <= '0;
      r_Cout  <= 1'b0;
      r_OV    <= 1'b0;
    end else if (w_accept) begin
      // Carry-in of 1 with inverted B completes the two's-complement negate.
      r_opA   <= bus.A;
      r_opB   <= bus.sub ? ~bus.B : bus.B;
      r_carry <= bus.sub;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == c_SHIFT) begin
      r_opA   <= {1'b0, r_opA[WIDTH-1:1]};
      r_opB   <= {1'b0, r_opB[WIDTH-1:1]};
      r_acc   <= {w_s, r_acc[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // r_carry here is the carry into the MSB, so OV = Cin(msb) ^ Cout(msb).
        r_S    <= {w_s, r_acc[WIDTH-1:1]};
        r_Cout <= w_c;
        r_OV   <= r_carry ^ w_c;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.S    = r_S;
  assign bus.Cout = r_Cout;
  assign bus.OV   = r_OV;

endmodule
`default_nettype wire
